// File: rtl/pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : pc_sequencer
// Description : Fetch/execute controller owning the core PC; issues one
//               handshaked fetch at a time and selects the next PC.
// Revision    : 1.0 - initial release
// ============================================================================
module pc_sequencer #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter logic [31:0] TARGET_MASK = 32'h0000_FFFF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        run,
    input  logic        halt,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    input  logic        ex_done,
    input  logic        branch,
    input  logic        zero,
    input  logic        jalr,
    input  logic [31:0] imm,
    input  logic [31:0] rs1_data,
    output logic [31:0] pc,
    output logic        busy,
    output logic        misalign,
    output logic [31:0] retire_cnt
);

    localparam logic [1:0] c_IDLE   = 2'd0;
    localparam logic [1:0] c_FETCH  = 2'd1;
    localparam logic [1:0] c_EXEC   = 2'd2;
    localparam logic [1:0] c_HALTED = 2'd3;

    logic [1:0]  r_state;
    logic [31:0] r_pc;
    logic [31:0] r_inst;
    logic [31:0] r_inst_pc;
    logic        r_inst_valid;
    logic        r_misalign;
    logic [31:0] r_retire_cnt;
    logic        r_halt_pend;

    logic [31:0] w_seq_pc;
    logic [31:0] w_br_pc;
    logic [31:0] w_jalr_pc;
    logic [31:0] w_next_pc;
    logic        w_next_misalign;
    logic        w_retire_edge;
    logic        w_enter_halted;

    // Sequential PC wraps naturally and is never masked; taken targets are.
    assign w_seq_pc        = r_pc + 32'd4;
    assign w_br_pc         = (r_pc + imm) & TARGET_MASK;
    assign w_jalr_pc       = ((rs1_data + imm) & ~32'd1) & TARGET_MASK;
    assign w_next_pc       = (branch & zero) ? (jalr ? w_jalr_pc : w_br_pc) : w_seq_pc;
    assign w_next_misalign = w_next_pc[1];

    assign w_retire_edge  = (r_state == c_EXEC) && ex_done;
    assign w_enter_halted = w_retire_edge && (w_next_misalign || r_halt_pend || halt);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= c_IDLE;
            r_pc         <= RESET_PC;
            r_inst       <= 32'd0;
            r_inst_pc    <= 32'd0;
            r_inst_valid <= 1'b0;
            r_misalign   <= 1'b0;
            r_retire_cnt <= 32'd0;
            r_halt_pend  <= 1'b0;
        end else begin
            r_inst_valid <= 1'b0;

            if (w_enter_halted) begin
                r_halt_pend <= 1'b0;
            end else if (halt && (r_state != c_HALTED)) begin
                r_halt_pend <= 1'b1;
            end

            case (r_state)
                c_IDLE: begin
                    if (run && !r_halt_pend) begin
                        r_state <= c_FETCH;
                    end
                end
                c_FETCH: begin
                    if (imem_ready) begin
                        r_inst       <= imem_rdata;
                        r_inst_pc    <= r_pc;
                        r_inst_valid <= 1'b1;
                        r_state      <= c_EXEC;
                    end
                end
                c_EXEC: begin
                    if (ex_done) begin
                        if (w_next_misalign) begin
                            r_misalign <= 1'b1;
                            r_state    <= c_HALTED;
                        end else begin
                            r_pc         <= w_next_pc;
                            r_retire_cnt <= r_retire_cnt + 32'd1;
                            if (r_halt_pend || halt) begin
                                r_state <= c_HALTED;
                            end else if (run) begin
                                r_state <= c_FETCH;
                            end else begin
                                r_state <= c_IDLE;
                            end
                        end
                    end
                end
                default: begin
                    if (!run) begin
                        r_state <= c_IDLE;
                    end
                end
            endcase
        end
    end

    // Request decodes straight from state so an async reset drops it at once.
    assign imem_req   = (r_state == c_FETCH);
    assign imem_addr  = imem_req ? r_pc : 32'd0;
    assign inst_valid = r_inst_valid;
    assign inst       = r_inst;
    assign inst_pc    = r_inst_pc;
    assign pc         = r_pc;
    assign busy       = (r_state == c_FETCH) || (r_state == c_EXEC);
    assign misalign   = r_misalign;
    assign retire_cnt = r_retire_cnt;

endmodule
`default_nettype wire

// File: tb/tb_pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_pc_sequencer
// Description : Directed self-checking bench for pc_sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        run;
    logic        halt;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    wire  [31:0] imem_rdata;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        ex_done;
    logic        branch;
    logic        zero;
    logic        jalr;
    logic [31:0] imm;
    logic [31:0] rs1_data;
    logic [31:0] pc;
    logic        busy;
    logic        misalign;
    logic [31:0] retire_cnt;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    // Instruction word tags its own address so latched data is traceable.
    assign imem_rdata = {16'hC0DE, imem_addr[15:0]};

    pc_sequencer #(
        .RESET_PC   (32'h0000_0000),
        .TARGET_MASK(32'h0000_FFFF)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .run       (run),
        .halt      (halt),
        .imem_req  (imem_req),
        .imem_addr (imem_addr),
        .imem_ready(imem_ready),
        .imem_rdata(imem_rdata),
        .inst_valid(inst_valid),
        .inst      (inst),
        .inst_pc   (inst_pc),
        .ex_done   (ex_done),
        .branch    (branch),
        .zero      (zero),
        .jalr      (jalr),
        .imm       (imm),
        .rs1_data  (rs1_data),
        .pc        (pc),
        .busy      (busy),
        .misalign  (misalign),
        .retire_cnt(retire_cnt)
    );

    task automatic wait_exec(input string tag);
        int n = 0;
        while (inst_valid !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (inst_valid !== 1'b1) begin
            failures++;
            $display("FAIL %s_timeout inst_valid=%b required=1", tag, inst_valid);
        end
    endtask

    // Called at a negedge in EXEC; returns at the negedge after the ex_done edge.
    task automatic retire(input logic b, input logic z, input logic j,
                          input logic [31:0] im, input logic [31:0] rs, input logic h);
        branch = b; zero = z; jalr = j; imm = im; rs1_data = rs; halt = h;
        ex_done = 1'b1;
        @(negedge clk);
        ex_done = 1'b0; branch = 1'b0; zero = 1'b0; jalr = 1'b0;
        imm = 32'd0; rs1_data = 32'd0; halt = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; run = 1'b0; halt = 1'b0; imem_ready = 1'b0; ex_done = 1'b0;
        branch = 1'b0; zero = 1'b0; jalr = 1'b0; imm = 32'd0; rs1_data = 32'd0;
        repeat (2) @(negedge clk);
        checks++;
        if (pc !== 32'h0) begin failures++; $display("FAIL reset_pc got=%h exp=0", pc); end
        checks++;
        if (imem_req !== 1'b0 || busy !== 1'b0 || inst_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_ctrl got req=%b busy=%b iv=%b exp=0,0,0", imem_req, busy, inst_valid);
        end
        checks++;
        if (misalign !== 1'b0 || retire_cnt !== 32'd0 || inst !== 32'd0 || inst_pc !== 32'd0) begin
            failures++;
            $display("FAIL reset_regs got mis=%b cnt=%h inst=%h ipc=%h exp=0", misalign, retire_cnt, inst, inst_pc);
        end
    endtask

    task automatic test_sequential();
        logic [31:0] a;
        run = 1'b1; imem_ready = 1'b1; ex_done = 1'b1;
        rst_n = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            a = 32'(4 * ((i - 1) / 2));
            checks++;
            if (i % 2 == 1) begin
                if (imem_req !== 1'b1 || imem_addr !== a) begin
                    failures++;
                    $display("FAIL seq_fetch%0d got req=%b addr=%h exp req=1 addr=%h", i, imem_req, imem_addr, a);
                end
            end else begin
                if (imem_req !== 1'b0 || inst_valid !== 1'b1 || inst_pc !== a || inst !== {16'hC0DE, a[15:0]}) begin
                    failures++;
                    $display("FAIL seq_exec%0d got req=%b iv=%b ipc=%h inst=%h exp 0,1,%h,%h",
                             i, imem_req, inst_valid, inst_pc, inst, a, {16'hC0DE, a[15:0]});
                end
            end
        end
        @(negedge clk);
        ex_done = 1'b0;
        checks++;
        if (retire_cnt !== 32'd4 || pc !== 32'h10) begin
            failures++;
            $display("FAIL seq_count got cnt=%0d pc=%h exp cnt=4 pc=10", retire_cnt, pc);
        end
    endtask

    task automatic test_mem_wait();
        int req_cycles = 0;
        int pulses = 0;
        imem_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (imem_req === 1'b1 && imem_addr === 32'h10) req_cycles++;
            if (i == 3) imem_ready = 1'b1;
            @(negedge clk);
        end
        checks++;
        if (inst_pc !== 32'h10) begin failures++; $display("FAIL wait_inst_pc got=%h exp=10", inst_pc); end
        for (int i = 0; i < 3; i++) begin
            if (inst_valid === 1'b1) pulses++;
            @(negedge clk);
        end
        checks++;
        if (req_cycles != 4) begin failures++; $display("FAIL wait_req_cycles got=%0d exp=4", req_cycles); end
        checks++;
        if (pulses != 1) begin failures++; $display("FAIL wait_pulses got=%0d exp=1", pulses); end
    endtask

    task automatic test_branch_mask();
        retire(1'b1, 1'b1, 1'b1, 32'd0, 32'hFFF0, 1'b0);
        checks++;
        if (pc !== 32'hFFF0 || retire_cnt !== 32'd5) begin
            failures++; $display("FAIL br_setup got pc=%h cnt=%0d exp FFF0,5", pc, retire_cnt);
        end
        wait_exec("br_taken");
        retire(1'b1, 1'b1, 1'b0, 32'h20, 32'd0, 1'b0);
        checks++;
        if (pc !== 32'h10 || retire_cnt !== 32'd6) begin
            failures++; $display("FAIL br_taken_mask got pc=%h cnt=%0d exp 10,6", pc, retire_cnt);
        end
        wait_exec("br_setup2");
        retire(1'b1, 1'b1, 1'b1, 32'd0, 32'hFFF0, 1'b0);
        wait_exec("br_not_taken");
        retire(1'b1, 1'b0, 1'b0, 32'h20, 32'd0, 1'b0);
        checks++;
        if (pc !== 32'hFFF4 || retire_cnt !== 32'd8) begin
            failures++; $display("FAIL br_not_taken got pc=%h cnt=%0d exp FFF4,8", pc, retire_cnt);
        end
    endtask

    task automatic test_jalr();
        wait_exec("jalr");
        retire(1'b1, 1'b1, 1'b1, 32'd0, 32'h0001_2345, 1'b0);
        checks++;
        if (pc !== 32'h2344 || imem_req !== 1'b1 || imem_addr !== 32'h2344) begin
            failures++; $display("FAIL jalr_target got pc=%h req=%b addr=%h exp 2344,1,2344", pc, imem_req, imem_addr);
        end
    endtask

    task automatic test_misalign();
        int reqs = 0;
        wait_exec("mis_setup");
        retire(1'b1, 1'b1, 1'b1, 32'd0, 32'h100, 1'b0);
        wait_exec("mis_branch");
        retire(1'b1, 1'b1, 1'b0, 32'd6, 32'd0, 1'b0);
        checks++;
        if (misalign !== 1'b1 || pc !== 32'h100 || retire_cnt !== 32'd10 || busy !== 1'b0) begin
            failures++;
            $display("FAIL misalign_trap got mis=%b pc=%h cnt=%0d busy=%b exp 1,100,10,0", misalign, pc, retire_cnt, busy);
        end
        ex_done = 1'b1; branch = 1'b1; zero = 1'b1; imm = 32'h40;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (imem_req === 1'b1) reqs++;
        end
        ex_done = 1'b0; branch = 1'b0; zero = 1'b0; imm = 32'd0;
        checks++;
        if (reqs != 0 || pc !== 32'h100 || retire_cnt !== 32'd10) begin
            failures++; $display("FAIL misalign_halted got reqs=%0d pc=%h cnt=%0d exp 0,100,10", reqs, pc, retire_cnt);
        end
    endtask

    task automatic test_async_reset();
        run = 1'b0;
        @(negedge clk);
        run = 1'b1; imem_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h100 || misalign !== 1'b1) begin
            failures++; $display("FAIL resume_fetch got req=%b addr=%h mis=%b exp 1,100,1", imem_req, imem_addr, misalign);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (imem_req !== 1'b0 || pc !== 32'h0 || misalign !== 1'b0 || retire_cnt !== 32'd0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL async_reset got req=%b pc=%h mis=%b cnt=%0d busy=%b exp 0", imem_req, pc, misalign, retire_cnt, busy);
        end
        @(negedge clk);
        imem_ready = 1'b1;
        rst_n = 1'b1;
    endtask

    task automatic test_halt();
        int reqs = 0;
        wait_exec("halt_setup");
        retire(1'b1, 1'b1, 1'b1, 32'd0, 32'h20, 1'b0);
        halt = 1'b1; imem_ready = 1'b0;
        @(negedge clk);
        halt = 1'b0; imem_ready = 1'b1;
        @(negedge clk);
        retire(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
        checks++;
        if (pc !== 32'h24 || retire_cnt !== 32'd2 || busy !== 1'b0 || imem_req !== 1'b0) begin
            failures++;
            $display("FAIL halt_retire got pc=%h cnt=%0d busy=%b req=%b exp 24,2,0,0", pc, retire_cnt, busy, imem_req);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (imem_req === 1'b1) reqs++;
        end
        checks++;
        if (reqs != 0) begin failures++; $display("FAIL halt_no_fetch got reqs=%0d exp=0", reqs); end
        run = 1'b0;
        @(negedge clk);
        run = 1'b1;
        @(negedge clk);
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h24) begin
            failures++; $display("FAIL halt_resume got req=%b addr=%h exp 1,24", imem_req, imem_addr);
        end
    endtask

    task automatic test_back_to_back();
        wait_exec("b2b");
        retire(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b1);
        checks++;
        if (pc !== 32'h28 || retire_cnt !== 32'd3 || busy !== 1'b0) begin
            failures++; $display("FAIL halt_with_done got pc=%h cnt=%0d busy=%b exp 28,3,0", pc, retire_cnt, busy);
        end
        @(negedge clk);
        checks++;
        if (imem_req !== 1'b0 || busy !== 1'b0) begin
            failures++; $display("FAIL halt_with_done_stay got req=%b busy=%b exp 0,0", imem_req, busy);
        end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_mem_wait();
        test_branch_mask();
        test_jalr();
        test_misalign();
        test_async_reset();
        test_halt();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
